// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared types and ROM marker codes for the OV7670 config sequencer
package ov7670_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_SEND,
        ST_DELAY,
        ST_DONE
    } cfg_state_t;

    localparam logic [15:0] ROM_END   = 16'hFFFF;
    localparam logic [15:0] ROM_DELAY = 16'hFFF0;

    // A one-cycle delay still needs a 1-bit counter to hold the value 0.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// rtl/cfg_delay_timer.sv - loadable down-counter with a zero flag for timed ROM delays
module cfg_delay_timer #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ov7670_cfg_sequencer.sv
// rtl/ov7670_cfg_sequencer.sv - walks the OV7670 register ROM and feeds each entry to the SCCB master
module ov7670_cfg_sequencer
    import ov7670_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DELAY_CYCLES = 1_000_000,
    parameter int AUTO_START   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_dout,
    output logic              sccb_valid,
    input  logic              sccb_ready,
    output logic [7:0]        sccb_reg,
    output logic [7:0]        sccb_data,
    output logic              busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam int                CNT_W      = cnt_width(DELAY_CYCLES);
    localparam logic [CNT_W-1:0]  DELAY_LOAD = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;
    localparam logic              AUTO_EN    = (AUTO_START != 0);

    cfg_state_t        state, state_nxt;
    logic              auto_pend;
    logic [ADDR_W-1:0] addr_nxt;
    logic              valid_nxt;
    logic [7:0]        reg_nxt;
    logic [7:0]        data_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              err_nxt;
    logic              advance;
    logic              tmr_load;
    logic              tmr_dec;
    logic              tmr_zero;

    cfg_delay_timer #(
        .WIDTH (CNT_W)
    ) u_delay_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .load_value (DELAY_LOAD),
        .dec        (tmr_dec),
        .zero       (tmr_zero)
    );

    always_comb begin
        state_nxt = state;
        addr_nxt  = rom_addr;
        valid_nxt = sccb_valid;
        reg_nxt   = sccb_reg;
        data_nxt  = sccb_data;
        busy_nxt  = busy;
        done_nxt  = cfg_done;
        err_nxt   = cfg_err;
        advance   = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                // auto_pend is only ever high in the first cycle out of reset, i.e. in IDLE
                if (start || auto_pend) begin
                    addr_nxt  = '0;
                    done_nxt  = 1'b0;
                    err_nxt   = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (rom_dout == ROM_END) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = ST_DONE;
                end else if (rom_dout == ROM_DELAY) begin
                    tmr_load  = 1'b1;
                    state_nxt = ST_DELAY;
                end else begin
                    reg_nxt   = rom_dout[15:8];
                    data_nxt  = rom_dout[7:0];
                    valid_nxt = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (sccb_ready) begin
                    valid_nxt = 1'b0;
                    advance   = 1'b1;
                end
            end
            ST_DELAY: begin
                if (tmr_zero) begin
                    advance = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Running off the end of the ROM without an end marker is a malformed table.
        if (advance) begin
            if (rom_addr == ADDR_LAST) begin
                err_nxt   = 1'b1;
                done_nxt  = 1'b0;
                busy_nxt  = 1'b0;
                state_nxt = ST_DONE;
            end else begin
                addr_nxt  = rom_addr + ADDR_W'(1);
                state_nxt = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            auto_pend  <= AUTO_EN;
            rom_addr   <= '0;
            sccb_valid <= 1'b0;
            sccb_reg   <= '0;
            sccb_data  <= '0;
            busy       <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            auto_pend  <= 1'b0;
            rom_addr   <= addr_nxt;
            sccb_valid <= valid_nxt;
            sccb_reg   <= reg_nxt;
            sccb_data  <= data_nxt;
            busy       <= busy_nxt;
            cfg_done   <= done_nxt;
            cfg_err    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// tb/tb_ov7670_cfg_sequencer.sv - directed self-checking bench for ov7670_cfg_sequencer
module tb_ov7670_cfg_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Instance A: auto start, short delay
    logic        rst_a = 1'b0;
    logic        start_a = 1'b0;
    logic [7:0]  rom_addr_a;
    logic [15:0] rom_dout_a;
    logic        valid_a;
    logic        ready_a = 1'b1;
    logic [7:0]  reg_a, data_a;
    logic        busy_a, done_a, err_a;
    logic [15:0] rom_a [0:255];
    logic [15:0] log_a [$];
    int          logcyc_a [$];

    // Instance B: waits for start
    logic        rst_b = 1'b0;
    logic        start_b = 1'b0;
    logic [7:0]  rom_addr_b;
    logic [15:0] rom_dout_b;
    logic        valid_b;
    logic        ready_b = 1'b1;
    logic [7:0]  reg_b, data_b;
    logic        busy_b, done_b, err_b;
    logic [15:0] rom_b [0:255];
    logic [15:0] log_b [$];
    int          logcyc_b [$];

    ov7670_cfg_sequencer #(.ADDR_W(8), .DELAY_CYCLES(8), .AUTO_START(1)) dut_a (
        .clk(clk), .reset_n(rst_a), .start(start_a), .rom_addr(rom_addr_a), .rom_dout(rom_dout_a),
        .sccb_valid(valid_a), .sccb_ready(ready_a), .sccb_reg(reg_a), .sccb_data(data_a),
        .busy(busy_a), .cfg_done(done_a), .cfg_err(err_a)
    );

    ov7670_cfg_sequencer #(.ADDR_W(8), .DELAY_CYCLES(8), .AUTO_START(0)) dut_b (
        .clk(clk), .reset_n(rst_b), .start(start_b), .rom_addr(rom_addr_b), .rom_dout(rom_dout_b),
        .sccb_valid(valid_b), .sccb_ready(ready_b), .sccb_reg(reg_b), .sccb_data(data_b),
        .busy(busy_b), .cfg_done(done_b), .cfg_err(err_b)
    );

    always @(posedge clk) rom_dout_a <= rom_a[rom_addr_a];
    always @(posedge clk) rom_dout_b <= rom_b[rom_addr_b];

    // Inputs change #1 after posedge, so at negedge valid&ready means a transfer at the next edge.
    always @(negedge clk) begin
        if (rst_a && valid_a && ready_a) begin
            log_a.push_back({reg_a, data_a});
            logcyc_a.push_back(cyc);
        end
        if (rst_b && valid_b && ready_b) begin
            log_b.push_back({reg_b, data_b});
            logcyc_b.push_back(cyc);
        end
    end

    function automatic logic [15:0] la(input int i);
        return (i < log_a.size()) ? log_a[i] : 16'hxxxx;
    endfunction

    function automatic int lca(input int i);
        return (i < logcyc_a.size()) ? logcyc_a[i] : -1000;
    endfunction

    task automatic prep_a();
        rst_a   = 1'b0;
        start_a = 1'b0;
        ready_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        log_a.delete();
        logcyc_a.delete();
        for (int i = 0; i < 256; i++) rom_a[i] = 16'hFFFF;
    endtask

    task automatic release_a(output int n0);
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        n0 = cyc;
    endtask

    task automatic wait_end_a(input int bound, input string name);
        int n = 0;
        while (!(done_a || err_a) && n < bound) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!(done_a || err_a)) begin
            bad++;
            $display("FAIL %s_timeout: done=%b err=%b after %0d cycles, want done or err", name, done_a, err_a, n);
        end
    endtask

    task automatic load_delay_table();
        rom_a[0] = 16'h1280;
        rom_a[1] = 16'hFFF0;
        rom_a[2] = 16'h1214;
        rom_a[3] = 16'hFFFF;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (rom_addr_a !== 8'd0) begin bad++; $display("FAIL reset_addr: got %h want 00", rom_addr_a); end
        total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_a); end
        total++; if ({reg_a, data_a} !== 16'h0000) begin bad++; $display("FAIL reset_payload: got %h want 0000", {reg_a, data_a}); end
        total++; if ({busy_a, done_a, err_a} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {busy_a, done_a, err_a}); end
    endtask

    task automatic test_delay();
        int n0;
        prep_a();
        load_delay_table();
        release_a(n0);
        wait_end_a(200, "delay");
        total++; if (log_a.size() !== 2) begin bad++; $display("FAIL delay_count: got %0d want 2", log_a.size()); end
        total++; if (la(0) !== 16'h1280) begin bad++; $display("FAIL delay_first: got %h want 1280", la(0)); end
        total++; if (la(1) !== 16'h1214) begin bad++; $display("FAIL delay_second: got %h want 1214", la(1)); end
        total++; if (lca(0) !== n0 + 3) begin bad++; $display("FAIL delay_latency: got %0d want %0d", lca(0), n0 + 3); end
        total++; if (lca(1) - lca(0) !== 13) begin bad++; $display("FAIL delay_gap: got %0d want 13", lca(1) - lca(0)); end
        total++; if ({busy_a, done_a, err_a} !== 3'b010) begin bad++; $display("FAIL delay_flags: got %b want 010", {busy_a, done_a, err_a}); end
        total++; if (rom_addr_a !== 8'd3) begin bad++; $display("FAIL delay_addr: got %h want 03", rom_addr_a); end
    endtask

    task automatic test_stall();
        int n0;
        int n = 0;
        int unstable = 0;
        prep_a();
        rom_a[0] = 16'h3A04;
        ready_a  = 1'b0;
        release_a(n0);
        while (!valid_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++; if (valid_a !== 1'b1) begin bad++; $display("FAIL stall_valid_rise: got %b want 1", valid_a); end
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            if (valid_a !== 1'b1 || reg_a !== 8'h3A || data_a !== 8'h04 || busy_a !== 1'b1) unstable++;
        end
        total++; if (unstable !== 0) begin bad++; $display("FAIL stall_hold: got %0d unstable cycles want 0", unstable); end
        total++; if (log_a.size() !== 0) begin bad++; $display("FAIL stall_early: got %0d transfers want 0", log_a.size()); end
        @(posedge clk);
        #1 ready_a = 1'b1;
        wait_end_a(20, "stall");
        total++; if (log_a.size() !== 1) begin bad++; $display("FAIL stall_count: got %0d want 1", log_a.size()); end
        total++; if (la(0) !== 16'h3A04) begin bad++; $display("FAIL stall_payload: got %h want 3a04", la(0)); end
        total++; if (done_a !== 1'b1) begin bad++; $display("FAIL stall_done: got %b want 1", done_a); end
    endtask

    task automatic test_wrap();
        int n0;
        int order_bad = 0;
        prep_a();
        for (int i = 0; i < 256; i++) rom_a[i] = {8'h20, 8'(i)};
        release_a(n0);
        wait_end_a(1000, "wrap");
        for (int i = 0; i < 256; i++) if (la(i) !== {8'h20, 8'(i)}) order_bad++;
        total++; if (log_a.size() !== 256) begin bad++; $display("FAIL wrap_count: got %0d want 256", log_a.size()); end
        total++; if (order_bad !== 0) begin bad++; $display("FAIL wrap_order: got %0d wrong entries want 0", order_bad); end
        total++; if ({busy_a, done_a, err_a} !== 3'b001) begin bad++; $display("FAIL wrap_flags: got %b want 001", {busy_a, done_a, err_a}); end
        total++; if (rom_addr_a !== 8'hFF) begin bad++; $display("FAIL wrap_addr: got %h want ff", rom_addr_a); end
        repeat (6) @(negedge clk);
        total++; if (rom_addr_a !== 8'hFF || log_a.size() !== 256) begin
            bad++; $display("FAIL wrap_hold: got addr %h count %0d want ff 256", rom_addr_a, log_a.size());
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        int n = 0;
        prep_a();
        for (int i = 0; i < 8; i++) rom_a[i] = {8'h40, 8'(i)};
        release_a(n0);
        while (!(valid_a && data_a == 8'h05) && n < 60) begin
            @(negedge clk);
            n++;
        end
        total++; if ({valid_a, data_a} !== 9'h105) begin bad++; $display("FAIL mid_reach: got %h want 105", {valid_a, data_a}); end
        rst_a = 1'b0;
        #1;
        total++; if (valid_a !== 1'b0) begin bad++; $display("FAIL mid_valid_drop: got %b want 0", valid_a); end
        total++; if ({rom_addr_a, busy_a} !== 9'h000) begin bad++; $display("FAIL mid_state: got %h want 000", {rom_addr_a, busy_a}); end
        log_a.delete();
        logcyc_a.delete();
        release_a(n0);
        wait_end_a(100, "mid");
        total++; if (la(0) !== 16'h4000) begin bad++; $display("FAIL mid_restart_first: got %h want 4000", la(0)); end
        total++; if (log_a.size() !== 8) begin bad++; $display("FAIL mid_restart_count: got %0d want 8", log_a.size()); end
        total++; if (done_a !== 1'b1) begin bad++; $display("FAIL mid_done: got %b want 1", done_a); end
    endtask

    task automatic test_start_in_delay_and_done();
        int n0;
        prep_a();
        load_delay_table();
        release_a(n0);
        repeat (8) @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        wait_end_a(200, "sdelay");
        total++; if (log_a.size() !== 2) begin bad++; $display("FAIL sdelay_count: got %0d want 2", log_a.size()); end
        total++; if (la(1) !== 16'h1214) begin bad++; $display("FAIL sdelay_second: got %h want 1214", la(1)); end
        total++; if (lca(1) - lca(0) !== 13) begin bad++; $display("FAIL sdelay_gap: got %0d want 13", lca(1) - lca(0)); end
        log_a.delete();
        logcyc_a.delete();
        @(posedge clk);
        #1 start_a = 1'b1;
        @(negedge clk);
        total++; if (done_a !== 1'b1) begin bad++; $display("FAIL sdone_before: got %b want 1", done_a); end
        @(posedge clk);
        #1 start_a = 1'b0;
        @(negedge clk);
        total++; if ({busy_a, done_a} !== 2'b10) begin bad++; $display("FAIL sdone_clear: got %b want 10", {busy_a, done_a}); end
        wait_end_a(200, "sdone");
        total++; if (log_a.size() !== 2) begin bad++; $display("FAIL sdone_count: got %0d want 2", log_a.size()); end
        total++; if ({la(0), la(1)} !== 32'h1280_1214) begin bad++; $display("FAIL sdone_payload: got %h want 12801214", {la(0), la(1)}); end
        total++; if (done_a !== 1'b1) begin bad++; $display("FAIL sdone_done: got %b want 1", done_a); end
    endtask

    task automatic test_no_autostart();
        int n0;
        int n = 0;
        for (int i = 0; i < 256; i++) rom_b[i] = 16'hFFFF;
        rom_b[0] = 16'h5511;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        repeat (30) @(negedge clk);
        total++; if (log_b.size() !== 0) begin bad++; $display("FAIL noauto_writes: got %0d want 0", log_b.size()); end
        total++; if ({valid_b, busy_b, done_b, err_b} !== 4'b0000) begin
            bad++; $display("FAIL noauto_flags: got %b want 0000", {valid_b, busy_b, done_b, err_b});
        end
        total++; if (rom_addr_b !== 8'd0) begin bad++; $display("FAIL noauto_addr: got %h want 00", rom_addr_b); end
        @(posedge clk);
        #1 start_b = 1'b1;
        n0 = cyc;
        @(posedge clk);
        #1 start_b = 1'b0;
        while (!done_b && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++; if (done_b !== 1'b1) begin bad++; $display("FAIL noauto_done: got %b want 1", done_b); end
        total++; if (log_b.size() !== 1) begin bad++; $display("FAIL noauto_count: got %0d want 1", log_b.size()); end
        if (log_b.size() > 0) begin
            total++; if (log_b[0] !== 16'h5511) begin bad++; $display("FAIL noauto_payload: got %h want 5511", log_b[0]); end
            total++; if (logcyc_b[0] !== n0 + 3) begin bad++; $display("FAIL noauto_latency: got %0d want %0d", logcyc_b[0], n0 + 3); end
        end
    endtask

    initial begin
        test_reset();
        test_delay();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_start_in_delay_and_done();
        test_no_autostart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
